// File: rtl/dbg_pkg.sv
// Shared definitions for the cache debug-port load/dump engines:
// FSM state encoding, debug-port widths and the default BRAM depth.
package dbg_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      SEND  = 3'd3,
      FIN   = 3'd4
   } dump_state_e;

   localparam int DBG_WORD_BYTES     = 4;
   localparam int DBG_ADDR_W         = 32;
   localparam int DBG_DATA_W         = 32;
   localparam int DBG_WE_W           = 4;
   localparam int BRAM_WORDS_DEFAULT = 4096;

endpackage

// File: rtl/bram_dump_engine.sv
// Read-only dump of a debug-visible BRAM onto a valid/ready stream.
// Optional running checksum of accepted words: define DUMP_CHECKSUM_EN.
module bram_dump_engine
   import dbg_pkg::*;
#(
   parameter int BRAM_WORDS = BRAM_WORDS_DEFAULT,
   parameter int CNT_W      = 13
) (
   input  logic                  CPU_CLK,
   input  logic                  CPU_RST,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DBG_ADDR_W-1:0] start_addr,
   input  logic [CNT_W-1:0]      word_count,
   output logic [DBG_ADDR_W-1:0] dbg_a2,
   output logic [DBG_DATA_W-1:0] dbg_wd2,
   output logic [DBG_WE_W-1:0]   dbg_we2,
   input  logic [DBG_DATA_W-1:0] dbg_rd2,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DBG_ADDR_W-1:0] out_addr,
   output logic [DBG_DATA_W-1:0] out_data,
   output logic                  busy,
   output logic                  done,
   output logic [DBG_DATA_W-1:0] checksum
);

   dump_state_e           state_q, state_d;
   logic [DBG_ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [CNT_W-1:0]      rem_q, rem_d;
   logic [DBG_ADDR_W-1:0] dbg_a2_q, dbg_a2_d;
   logic [DBG_ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [DBG_DATA_W-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  done_q, done_d;

   logic [CNT_W-1:0]      clamped_count;
   logic [DBG_ADDR_W-1:0] aligned_start;
   logic [DBG_ADDR_W-1:0] next_addr;
   logic                  handshake;
   logic                  aborting;
   logic                  unused_addr_lsbs;

   assign clamped_count    = (word_count > CNT_W'(BRAM_WORDS)) ? CNT_W'(BRAM_WORDS) : word_count;
   assign aligned_start    = {start_addr[DBG_ADDR_W-1:2], 2'b00};
   assign unused_addr_lsbs = ^start_addr[1:0];
   assign next_addr        = cur_addr_q + DBG_ADDR_W'(DBG_WORD_BYTES);
   assign aborting         = abort && (state_q != IDLE);
   // An abort in the same cycle as a handshake wins: that word is not consumed.
   assign handshake        = (state_q == SEND) && out_valid_q && out_ready && !abort;

   always_ff @(posedge CPU_CLK) begin
      if (CPU_RST) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (clamped_count == '0) ? FIN : ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = SEND;
         SEND:    if (handshake) state_d = (rem_q == CNT_W'(1)) ? FIN : ISSUE;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (aborting) state_d = IDLE;
   end

   // dbg_a2 is loaded on entry to ISSUE so the synchronous BRAM returns data during WAIT.
   always_comb begin
      cur_addr_d  = cur_addr_q;
      rem_d       = rem_q;
      dbg_a2_d    = dbg_a2_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               cur_addr_d = aligned_start;
               dbg_a2_d   = aligned_start;
               rem_d      = clamped_count;
            end
         end
         WAIT: begin
            out_data_d  = dbg_rd2;
            out_addr_d  = cur_addr_q;
            out_valid_d = 1'b1;
         end
         SEND: begin
            if (handshake) begin
               out_valid_d = 1'b0;
               rem_d       = rem_q - CNT_W'(1);
               cur_addr_d  = next_addr;
               dbg_a2_d    = next_addr;
            end
         end
         FIN:     done_d = 1'b1;
         default: ;
      endcase
      if (aborting) begin
         out_valid_d = 1'b0;
         done_d      = 1'b0;
      end
   end

   always_ff @(posedge CPU_CLK) begin
      if (CPU_RST) begin
         cur_addr_q  <= '0;
         rem_q       <= '0;
         dbg_a2_q    <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         cur_addr_q  <= cur_addr_d;
         rem_q       <= rem_d;
         dbg_a2_q    <= dbg_a2_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

`ifdef DUMP_CHECKSUM_EN
   logic [DBG_DATA_W-1:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (state_q == IDLE && start) checksum_d = '0;
      else if (handshake)           checksum_d = checksum_q + out_data_q;
   end

   always_ff @(posedge CPU_CLK) begin
      if (CPU_RST) checksum_q <= '0;
      else         checksum_q <= checksum_d;
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

   assign dbg_a2    = dbg_a2_q;
   assign dbg_wd2   = '0;
   assign dbg_we2   = '0;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign done      = done_q;
   // The done cycle is the tail of the dump, so busy drops only after it.
   assign busy      = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_bram_dump_engine.sv
// Scoreboard bench for bram_dump_engine: a driver queues expected beats per dump,
// a negedge monitor pops and compares every accepted beat.
module tb_bram_dump_engine;

   localparam int BW = 4096;

   logic        CPU_CLK = 1'b0;
   logic        CPU_RST = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] start_addr = '0;
   logic [12:0] word_count = '0;
   logic [31:0] dbg_a2, dbg_wd2, dbg_rd2;
   logic [3:0]  dbg_we2;
   logic        out_valid, busy, done;
   logic        out_ready = 1'b0;
   logic [31:0] out_addr, out_data, checksum;

   bram_dump_engine #(.BRAM_WORDS(BW), .CNT_W(13)) dut (
      .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST), .start(start), .abort(abort),
      .start_addr(start_addr), .word_count(word_count),
      .dbg_a2(dbg_a2), .dbg_wd2(dbg_wd2), .dbg_we2(dbg_we2), .dbg_rd2(dbg_rd2),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
      .busy(busy), .done(done), .checksum(checksum)
   );

   always #5 CPU_CLK = ~CPU_CLK;

   // Synchronous BRAM behind the debug port
   logic [31:0] mem [BW];
   always @(posedge CPU_CLK) dbg_rd2 <= mem[dbg_a2[13:2]];

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } beat_t;

   beat_t exp_q[$];
   int    n_cmp = 0;
   int    n_fail = 0;
   int    n_pop = 0;
   int    done_cnt = 0;
   int    ready_mode = 0;   // 0 always, 1 toggle, 2 random, 3 manual
   bit    abort_flag = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Monitor: every accepted beat is popped and compared; stalled beats must hold
   initial begin
      logic        prev_stall;
      logic [31:0] pa, pd;
      beat_t       b;
      prev_stall = 1'b0;
      pa = '0;
      pd = '0;
      forever begin
         @(negedge CPU_CLK);
         if (!CPU_RST && done) done_cnt++;
         if (CPU_RST || abort_flag) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid", 32'(out_valid), 32'd1);
               chk("stall_addr", out_addr, pa);
               chk("stall_data", out_data, pd);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL beat_unexpected: got addr %h data %h want no beat", out_addr, out_data);
               end else begin
                  b = exp_q.pop_front();
                  chk("beat_addr", out_addr, b.a);
                  chk("beat_data", out_data, b.d);
                  n_pop++;
               end
            end
            prev_stall = out_valid && !out_ready;
            pa = out_addr;
            pd = out_data;
         end
      end
   end

   // Consumer ready pattern
   initial forever begin
      @(posedge CPU_CLK);
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = !out_ready;
         2:       out_ready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   end

   // Reference: n = min(count, BW) words at aligned base + 4*i, modulo 2^32
   function automatic logic [31:0] push_expected(input logic [31:0] a, input int cnt);
      logic [31:0] base, addr, sum;
      int          n;
      n    = (cnt > BW) ? BW : cnt;
      base = a & 32'hFFFF_FFFC;
      sum  = '0;
      for (int i = 0; i < n; i++) begin
         addr = base + 32'(i) * 32'd4;
         exp_q.push_back('{a: addr, d: mem[addr[13:2]]});
         sum += mem[addr[13:2]];
      end
`ifdef DUMP_CHECKSUM_EN
      return sum;
`else
      return 32'h0;
`endif
   endfunction

   task automatic do_dump(input logic [31:0] a, input int cnt, input int mode,
                          input bit chk_lat, input bit extras);
      logic [31:0] exp_ck;
      int          d0, c;
      bit          got;
      exp_ck     = push_expected(a, cnt);
      d0         = done_cnt;
      ready_mode = mode;
      @(posedge CPU_CLK); #1;
      start = 1'b1; start_addr = a; word_count = 13'(cnt);
      if (extras) abort = 1'b1;
      @(posedge CPU_CLK); #1;
      start = 1'b0; abort = 1'b0;
      start_addr = $urandom; word_count = 13'($urandom);
      if (extras) begin
         // start while busy must be ignored
         @(posedge CPU_CLK); #1;
         start = 1'b1;
         @(posedge CPU_CLK); #1;
         start = 1'b0;
      end
      if (chk_lat) begin
         @(negedge CPU_CLK);
         chk("issue_a2", dbg_a2, a & 32'hFFFF_FFFC);
         chk("issue_valid", 32'(out_valid), 32'd0);
         chk("busy_running", 32'(busy), 32'd1);
         @(negedge CPU_CLK);
         chk("wait_valid", 32'(out_valid), 32'd0);
         @(negedge CPU_CLK);
         chk("first_valid_t3", 32'(out_valid), 32'd1);
      end
      c = 0;
      got = 1'b0;
      while (c < 20000 && !got) begin
         @(negedge CPU_CLK);
         c++;
         got = done;
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_timeout: got no done after %0d cycles want done", c);
      end
      if (cnt == 0 && !chk_lat && !extras) chk("zero_done_lat", 32'(c), 32'd2);
      chk("busy_at_done", 32'(busy), 32'd1);
      chk("checksum_at_done", checksum, exp_ck);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("we2_zero", 32'(dbg_we2), 32'd0);
      chk("wd2_zero", dbg_wd2, 32'd0);
      @(negedge CPU_CLK);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("done_count", 32'(done_cnt - d0), 32'd1);
      chk("checksum_hold", checksum, exp_ck);
      exp_q.delete();
      $display("dump addr=%h count=%0d mode=%0d cycles=%0d", a, cnt, mode, c);
   endtask

   // Abort (or reset) during the second SEND of a 4-word dump from address 0
   task automatic interrupt(input bit use_reset);
      logic [31:0] ck_unused;
      int          d0, p0, c;
      ck_unused  = push_expected(32'h0, 4);
      d0         = done_cnt;
      p0         = n_pop;
      ready_mode = 3;
      out_ready  = 1'b1;
      @(posedge CPU_CLK); #1;
      start = 1'b1; start_addr = 32'h0; word_count = 13'd4;
      @(posedge CPU_CLK); #1;
      start = 1'b0;
      c = 0;
      while (c < 50 && n_pop != p0 + 1) begin
         @(posedge CPU_CLK); #1;
         c++;
      end
      out_ready = 1'b0;
      c = 0;
      while (c < 50 && !out_valid) begin
         @(posedge CPU_CLK); #1;
         c++;
      end
      chk("second_send_valid", 32'(out_valid), 32'd1);
      abort_flag = 1'b1;
      out_ready  = 1'b1;   // a same-cycle handshake must lose to abort/reset
      if (use_reset) CPU_RST = 1'b1;
      else           abort = 1'b1;
      @(posedge CPU_CLK); #1;
      abort = 1'b0; CPU_RST = 1'b0; out_ready = 1'b0;
      @(negedge CPU_CLK);
      chk("intr_valid", 32'(out_valid), 32'd0);
      chk("intr_busy", 32'(busy), 32'd0);
      chk("intr_done", 32'(done), 32'd0);
      if (use_reset) begin
         chk("rst_out_addr", out_addr, 32'd0);
         chk("rst_out_data", out_data, 32'd0);
         chk("rst_dbg_a2", dbg_a2, 32'd0);
         chk("rst_checksum", checksum, 32'd0);
      end
      repeat (5) @(negedge CPU_CLK);
      chk("intr_no_done", 32'(done_cnt - d0), 32'd0);
      chk("intr_consumed", 32'(n_pop - p0), 32'd1);
      chk("intr_left", 32'(exp_q.size()), 32'd3);
      exp_q.delete();
      abort_flag = 1'b0;
      $display("interrupt reset=%0d", use_reset);
      do_dump(32'h0, 4, 0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < BW; i++) mem[i] = $urandom;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
      mem[16] = 32'hFFFF_FFFF; mem[17] = 32'h2;

      repeat (3) @(posedge CPU_CLK);
      #1 CPU_RST = 1'b0;
      @(negedge CPU_CLK);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_a2", dbg_a2, 32'd0);
      chk("rst_addr", out_addr, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_cksum", checksum, 32'd0);
      chk("rst_we2", 32'(dbg_we2), 32'd0);

      do_dump(32'h0, 4, 0, 1'b1, 1'b0);
      do_dump(32'h0, 4, 1, 1'b0, 1'b0);
      do_dump(32'h0, 0, 0, 1'b0, 1'b0);
      do_dump(32'h100, 5000, 0, 1'b0, 1'b0);
      do_dump(32'hFFFF_FFF8, 3, 2, 1'b0, 1'b0);
      do_dump(32'h5, 1, 0, 1'b1, 1'b0);
      do_dump(32'h40, 2, 1, 1'b0, 1'b0);
      do_dump(32'h20, 3, 0, 1'b0, 1'b1);
      interrupt(1'b0);
      interrupt(1'b1);
      for (int i = 0; i < 20; i++) begin
         int cnt;
         cnt = int'($urandom_range(0, 12));
         do_dump($urandom, cnt, int'($urandom_range(0, 2)), 1'b0, (cnt > 0) && (i % 3 == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
